// File: rtl/block_read_reducer.sv
// block_read_reducer
//   Consumes one block-read burst from the multiplier's product buffer and reduces it to
//   sum / max / min / word count. The result is held on a valid/ready port until it is accepted.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   start           request one reduction (sampled only in IDLE)
//   busy            high in every state except IDLE
//   EN_blockRead    block-read request to the multiplier (high only in REQ)
//   VALID_memVal    burst word valid
//   memVal_data     burst word (unsigned)
//   res_valid       result held valid
//   res_ready       sink accepts the result
//   res_sum         sum of the captured words
//   res_max         largest captured word (0 if none)
//   res_min         smallest captured word (0 if none)
//   res_count       number of words captured, 0..2**LOGDEPTH
//   res_err         no word arrived before the timeout
//   res_ovf         burst was longer than 2**LOGDEPTH words; the extra words were dropped
module block_read_reducer #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned LOGDEPTH = 6,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      EN_blockRead,
    input  logic                      VALID_memVal,
    input  logic [WIDTH-1:0]          memVal_data,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [WIDTH+LOGDEPTH:0]   res_sum,
    output logic [WIDTH-1:0]          res_max,
    output logic [WIDTH-1:0]          res_min,
    output logic [LOGDEPTH:0]         res_count,
    output logic                      res_err,
    output logic                      res_ovf
);

    localparam int unsigned SW = WIDTH + LOGDEPTH + 1;
    localparam int unsigned CW = LOGDEPTH + 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] MaxCount = CW'(2 ** LOGDEPTH);
    localparam logic [TW-1:0] TmoLast  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StStream, StDone} state_e;

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              en_q, en_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [SW-1:0]     sum_acc_q, sum_acc_d;
    logic [WIDTH-1:0]  max_acc_q, max_acc_d;
    logic [WIDTH-1:0]  min_acc_q, min_acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_acc_q, ovf_acc_d;
    logic              res_valid_q, res_valid_d;
    logic [SW-1:0]     res_sum_q, res_sum_d;
    logic [WIDTH-1:0]  res_max_q, res_max_d;
    logic [WIDTH-1:0]  res_min_q, res_min_d;
    logic [CW-1:0]     res_count_q, res_count_d;
    logic              res_err_q, res_err_d;
    logic              res_ovf_q, res_ovf_d;

    logic capture;
    logic finish;
    logic finish_err;

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        en_d        = en_q;
        tmo_d       = tmo_q;
        sum_acc_d   = sum_acc_q;
        max_acc_d   = max_acc_q;
        min_acc_d   = min_acc_q;
        cnt_d       = cnt_q;
        ovf_acc_d   = ovf_acc_q;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_max_d   = res_max_q;
        res_min_d   = res_min_q;
        res_count_d = res_count_q;
        res_err_d   = res_err_q;
        res_ovf_d   = res_ovf_q;
        finish      = 1'b0;
        finish_err  = 1'b0;
        capture     = VALID_memVal && (state_q == StReq || state_q == StStream);

        // Words past the buffer depth only flag overflow; they never touch the statistics.
        if (capture) begin
            if (cnt_q == MaxCount) begin
                ovf_acc_d = 1'b1;
            end else begin
                sum_acc_d = sum_acc_q + SW'(memVal_data);
                cnt_d     = cnt_q + 1'b1;
                if (memVal_data > max_acc_q) max_acc_d = memVal_data;
                if (memVal_data < min_acc_q) min_acc_d = memVal_data;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StReq;
                    busy_d    = 1'b1;
                    en_d      = 1'b1;
                    tmo_d     = '0;
                    sum_acc_d = '0;
                    max_acc_d = '0;
                    min_acc_d = '1;
                    cnt_d     = '0;
                    ovf_acc_d = 1'b0;
                end
            end
            StReq: begin
                if (VALID_memVal) begin
                    state_d = StStream;
                    en_d    = 1'b0;
                end else if (tmo_q == TmoLast) begin
                    state_d    = StDone;
                    en_d       = 1'b0;
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StStream: begin
                // No gap support: the first idle cycle terminates the burst.
                if (!VALID_memVal) begin
                    state_d = StDone;
                    finish  = 1'b1;
                end
            end
            StDone: begin
                if (res_valid_q && res_ready) begin
                    state_d     = StIdle;
                    busy_d      = 1'b0;
                    res_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (finish) begin
            res_valid_d = 1'b1;
            res_sum_d   = sum_acc_q;
            res_max_d   = max_acc_q;
            // The min accumulator starts at all-ones; report 0 for an empty burst.
            res_min_d   = (cnt_q == '0) ? '0 : min_acc_q;
            res_count_d = cnt_q;
            res_err_d   = finish_err;
            res_ovf_d   = ovf_acc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            en_q        <= 1'b0;
            tmo_q       <= '0;
            sum_acc_q   <= '0;
            max_acc_q   <= '0;
            min_acc_q   <= '1;
            cnt_q       <= '0;
            ovf_acc_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_max_q   <= '0;
            res_min_q   <= '0;
            res_count_q <= '0;
            res_err_q   <= 1'b0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            en_q        <= en_d;
            tmo_q       <= tmo_d;
            sum_acc_q   <= sum_acc_d;
            max_acc_q   <= max_acc_d;
            min_acc_q   <= min_acc_d;
            cnt_q       <= cnt_d;
            ovf_acc_q   <= ovf_acc_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_max_q   <= res_max_d;
            res_min_q   <= res_min_d;
            res_count_q <= res_count_d;
            res_err_q   <= res_err_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    assign busy         = busy_q;
    assign EN_blockRead = en_q;
    assign res_valid    = res_valid_q;
    assign res_sum      = res_sum_q;
    assign res_max      = res_max_q;
    assign res_min      = res_min_q;
    assign res_count    = res_count_q;
    assign res_err      = res_err_q;
    assign res_ovf      = res_ovf_q;

endmodule

// File: tb/tb_block_read_reducer.sv
// Randomised bench for block_read_reducer against a burst-level reference model.
module tb_block_read_reducer;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned LOGDEPTH = 6;
    localparam int unsigned TIMEOUT  = 16;
    localparam int unsigned DEPTH    = 2 ** LOGDEPTH;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic                    busy;
    logic                    EN_blockRead;
    logic                    VALID_memVal;
    logic [WIDTH-1:0]        memVal_data;
    logic                    res_valid;
    logic                    res_ready;
    logic [WIDTH+LOGDEPTH:0] res_sum;
    logic [WIDTH-1:0]        res_max;
    logic [WIDTH-1:0]        res_min;
    logic [LOGDEPTH:0]       res_count;
    logic                    res_err;
    logic                    res_ovf;

    int n_checks = 0;
    int n_errors = 0;
    logic [WIDTH-1:0] words [0:79];

    always #5 clk = ~clk;

    block_read_reducer #(
        .WIDTH    (WIDTH),
        .LOGDEPTH (LOGDEPTH),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .EN_blockRead (EN_blockRead),
        .VALID_memVal (VALID_memVal),
        .memVal_data  (memVal_data),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_sum      (res_sum),
        .res_max      (res_max),
        .res_min      (res_min),
        .res_count    (res_count),
        .res_err      (res_err),
        .res_ovf      (res_ovf)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full transaction: start, `delay` idle REQ cycles, `n` back-to-back words,
    // then `hold` cycles of back-pressure (with start pulses) before the accept.
    task automatic run_txn(input int delay, input int n, input int hold);
        logic [63:0] e_sum, e_max, e_min, e_cnt;
        logic        e_err, e_ovf, timeout;
        logic [63:0] s_sum;
        int kept, idle_cycles;

        timeout = (delay >= int'(TIMEOUT));
        kept    = (n > int'(DEPTH)) ? int'(DEPTH) : n;
        e_sum = 0; e_max = 0; e_min = 0; e_cnt = 64'(kept);
        for (int i = 0; i < kept; i++) begin
            e_sum += 64'(words[i]);
            if (i == 0 || 64'(words[i]) > e_max) e_max = 64'(words[i]);
            if (i == 0 || 64'(words[i]) < e_min) e_min = 64'(words[i]);
        end
        e_err = timeout;
        e_ovf = (n > int'(DEPTH));

        // Stray VALID alongside start in IDLE must not be captured.
        start        = 1'b1;
        VALID_memVal = 1'($urandom_range(0, 1));
        memVal_data  = WIDTH'($urandom);
        @(negedge clk);
        start        = 1'b0;
        VALID_memVal = 1'b0;
        check_eq("busy_after_start", 64'(busy), 64'd1);
        check_eq("en_after_start", 64'(EN_blockRead), 64'd1);

        idle_cycles = timeout ? int'(TIMEOUT) : delay;
        for (int i = 0; i < idle_cycles; i++) begin
            VALID_memVal = 1'b0;
            memVal_data  = WIDTH'($urandom);
            @(negedge clk);
        end
        if (timeout) begin
            check_eq("tmo_en_drop", 64'(EN_blockRead), 64'd0);
        end else begin
            check_eq("req_en_held", 64'(EN_blockRead), 64'd1);
            for (int i = 0; i < n; i++) begin
                VALID_memVal = 1'b1;
                memVal_data  = words[i];
                @(negedge clk);
                if (i == 0) check_eq("en_drop_first_word", 64'(EN_blockRead), 64'd0);
                if (i == n - 1) check_eq("no_valid_midburst", 64'(res_valid), 64'd0);
            end
            VALID_memVal = 1'b0;
            memVal_data  = WIDTH'($urandom);
            @(negedge clk);
        end

        check_eq("res_valid_latency", 64'(res_valid), 64'd1);
        check_eq("res_sum", 64'(res_sum), e_sum);
        check_eq("res_max", 64'(res_max), e_max);
        check_eq("res_min", 64'(res_min), e_min);
        check_eq("res_count", 64'(res_count), e_cnt);
        check_eq("res_err", 64'(res_err), 64'(e_err));
        check_eq("res_ovf", 64'(res_ovf), 64'(e_ovf));

        for (int i = 0; i < hold; i++) begin
            res_ready    = 1'b0;
            start        = 1'($urandom_range(0, 1));
            VALID_memVal = 1'($urandom_range(0, 1));
            memVal_data  = WIDTH'($urandom);
            @(negedge clk);
            check_eq("hold_valid", 64'(res_valid), 64'd1);
            check_eq("hold_sum", 64'(res_sum), e_sum);
            check_eq("hold_count", 64'(res_count), e_cnt);
            check_eq("hold_en_low", 64'(EN_blockRead), 64'd0);
        end

        s_sum        = 64'(res_sum);
        res_ready    = 1'b1;
        start        = 1'b1;
        VALID_memVal = 1'b0;
        @(negedge clk);
        res_ready = 1'b0;
        start     = 1'b0;
        check_eq("accept_valid_low", 64'(res_valid), 64'd0);
        check_eq("accept_idle", 64'(busy), 64'd0);
        @(negedge clk);
        check_eq("no_queued_start", 64'(busy), 64'd0);
        check_eq("no_second_req", 64'(EN_blockRead), 64'd0);
        check_eq("sum_retained", 64'(res_sum), s_sum);
    endtask

    initial begin
        int d, n, h;
        rst = 1'b1; start = 1'b0; VALID_memVal = 1'b0; memVal_data = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_en", 64'(EN_blockRead), 64'd0);
        check_eq("rst_valid", 64'(res_valid), 64'd0);
        check_eq("rst_sum", 64'(res_sum), 64'd0);
        check_eq("rst_min", 64'(res_min), 64'd0);
        check_eq("rst_count", 64'(res_count), 64'd0);
        @(negedge clk);

        // 63 ascending words after a 3-cycle wait
        for (int i = 0; i < 63; i++) words[i] = WIDTH'(i + 1);
        run_txn(3, 63, 0);
        // pure timeout
        run_txn(TIMEOUT, 0, 2);
        // first word on the last permitted REQ cycle
        words[0] = 32'd77;
        run_txn(TIMEOUT - 1, 1, 0);
        // full depth of all-ones
        for (int i = 0; i < 64; i++) words[i] = '1;
        run_txn(0, 64, 1);
        // one word past depth is dropped
        for (int i = 0; i < 64; i++) words[i] = 32'd5;
        words[64] = '1;
        run_txn(1, 65, 0);
        // long back-pressure with start pulses in DONE
        for (int i = 0; i < 10; i++) words[i] = WIDTH'($urandom);
        run_txn(2, 10, 10);

        // reset mid-stream after word 20
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            VALID_memVal = 1'b1;
            memVal_data  = WIDTH'($urandom);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        VALID_memVal = 1'b0;
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_en", 64'(EN_blockRead), 64'd0);
        check_eq("midrst_valid", 64'(res_valid), 64'd0);
        repeat (2) @(negedge clk);
        check_eq("midrst_no_result", 64'(res_valid), 64'd0);
        for (int i = 0; i < 8; i++) words[i] = WIDTH'(100 - i);
        run_txn(0, 8, 0);

        for (int t = 0; t < 30; t++) begin
            d = $urandom_range(0, TIMEOUT + 1);
            n = (d >= int'(TIMEOUT)) ? 0 : $urandom_range(1, 70);
            h = $urandom_range(0, 6);
            for (int i = 0; i < 80; i++) begin
                case ($urandom_range(0, 5))
                    0: words[i] = '0;
                    1: words[i] = '1;
                    default: words[i] = WIDTH'($urandom);
                endcase
            end
            run_txn(d, n, h);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
